// File: rtl/multi_bank_monitor_if.sv
`default_nettype none
// ============================================================================
// multi_bank_monitor_pkg / multi_bank_monitor_if
// Shared SDRAM command/status types and the snooped bus bundle.
// Revision: 1.0
// ============================================================================
package multi_bank_monitor_pkg;

  // {CS,RAS,CAS,WE}; CS is active low, so any 1xxx is a deselect
  typedef enum logic [3:0] {
    CMD_MRS          = 4'b0000,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_PRECHARGE    = 4'b0010,
    CMD_ACTIVE       = 4'b0011,
    CMD_WRITE        = 4'b0100,
    CMD_READ         = 4'b0101,
    CMD_BURST_TERM   = 4'b0110,
    CMD_NOP          = 4'b0111
  } commands_t;

  typedef enum logic [1:0] {
    ONE_BYTE    = 2'd0,
    FOUR_BYTES  = 2'd1,
    EIGHT_BYTES = 2'd2
  } burst_size_t;

  typedef enum logic [1:0] {
    BANK_NOT_READY   = 2'd0,
    BANK_READ_READY  = 2'd1,
    BANK_WRITE_READY = 2'd2,
    BANK_FULL_READY  = 2'd3
  } bank_status_t;

endpackage

interface multi_bank_monitor_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) ();

  logic                                              CS;
  logic                                              RAS;
  logic                                              CAS;
  logic                                              WE;
  logic [BANK_W-1:0]                                 B;
  logic                                              A10;
  multi_bank_monitor_pkg::burst_size_t               pool_rburst_size;
  multi_bank_monitor_pkg::burst_size_t               pool_wburst_size;
  multi_bank_monitor_pkg::bank_status_t [NUM_BANKS-1:0] bank_status;
  logic [NUM_BANKS-1:0]                              bank_open;
  logic                                              all_idle;
  logic                                              cmd_err;
  logic [BANK_W-1:0]                                 cmd_err_bank;

  modport master (
    output CS, RAS, CAS, WE, B, A10, pool_rburst_size, pool_wburst_size,
    input  bank_status, bank_open, all_idle, cmd_err, cmd_err_bank
  );

  modport slave (
    input  CS, RAS, CAS, WE, B, A10, pool_rburst_size, pool_wburst_size,
    output bank_status, bank_open, all_idle, cmd_err, cmd_err_bank
  );

endinterface
`default_nettype wire

// File: rtl/multi_bank_monitor.sv
`default_nettype none
// ============================================================================
// multi_bank_monitor
// Snoops the SDRAM command bus and tracks per-bank readiness and open rows.
// Revision: 1.0
// ============================================================================
module multi_bank_monitor
  import multi_bank_monitor_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_MRD     = 2,
  parameter int T_RFC     = 4,
  parameter int RD_TAIL   = 2,
  parameter int WR_TAIL   = 1
) (
  input wire                  clk,
  input wire                  n_rst,
  multi_bank_monitor_if.slave bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Longest burst is 4 busy cycles, so the counter must cover at least that
  localparam int CNT_MAX = imax(imax(imax(T_RCD, T_RP), imax(T_MRD, T_RFC)),
                                imax(imax(RD_TAIL, WR_TAIL), 4));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_RCD  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] C_RP   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] C_MRD  = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] C_RFC  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] C_RDT  = CNT_W'(RD_TAIL - 1);
  localparam logic [CNT_W-1:0] C_WRT  = CNT_W'(WR_TAIL - 1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_ACTIVATING  = 4'd1,
    S_ACTIVE      = 4'd2,
    S_READING     = 4'd3,
    S_READ_SEMI   = 4'd4,
    S_WRITING     = 4'd5,
    S_WRITE_SEMI  = 4'd6,
    S_PRECHARGING = 4'd7,
    S_GLOBAL_BUSY = 4'd8
  } bank_state_t;

  function automatic logic [CNT_W-1:0] burst_load(input burst_size_t sz);
    case (sz)
      FOUR_BYTES:  return CNT_W'(1);
      EIGHT_BYTES: return CNT_W'(3);
      default:     return CNT_W'(0);
    endcase
  endfunction

  function automatic bank_status_t status_of(input bank_state_t s);
    case (s)
      S_IDLE, S_ACTIVE: return BANK_FULL_READY;
      S_READ_SEMI:      return BANK_READ_READY;
      S_WRITE_SEMI:     return BANK_WRITE_READY;
      default:          return BANK_NOT_READY;
    endcase
  endfunction

  function automatic logic is_open(input bank_state_t s);
    return s inside {S_ACTIVATING, S_ACTIVE, S_READING, S_READ_SEMI,
                     S_WRITING, S_WRITE_SEMI};
  endfunction

  bank_state_t                  r_state     [NUM_BANKS];
  logic [CNT_W-1:0]             r_cnt       [NUM_BANKS];
  bank_state_t                  w_nxt_state [NUM_BANKS];
  logic [CNT_W-1:0]             w_nxt_cnt   [NUM_BANKS];
  bank_status_t [NUM_BANKS-1:0] r_status;
  logic [NUM_BANKS-1:0]         r_open;
  logic                         r_err;
  logic [BANK_W-1:0]            r_err_bank;

  logic [3:0]        w_cmd;
  bank_state_t       w_tgt;
  logic              w_bank_cmd;
  logic              w_pre_all;
  logic              w_is_mrs;
  logic              w_global;
  logic              w_b_ok;
  logic              w_legal;
  logic              w_pa_blocked;
  logic              w_all_idle;
  logic              w_bank_go;
  logic              w_pa_go;
  logic              w_glob_go;
  logic              w_err;
  logic [BANK_W-1:0] w_err_bank;

  always_comb begin
    w_cmd        = {bus.CS, bus.RAS, bus.CAS, bus.WE};
    w_pre_all    = (w_cmd == CMD_PRECHARGE) && bus.A10;
    w_bank_cmd   = (w_cmd == CMD_ACTIVE) || (w_cmd == CMD_READ) ||
                   (w_cmd == CMD_WRITE) || ((w_cmd == CMD_PRECHARGE) && !bus.A10);
    w_is_mrs     = (w_cmd == CMD_MRS);
    w_global     = w_is_mrs || (w_cmd == CMD_AUTO_REFRESH);
    w_b_ok       = int'(bus.B) < NUM_BANKS;
    w_tgt        = S_IDLE;
    w_all_idle   = 1'b1;
    w_pa_blocked = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bus.B == BANK_W'(i)) w_tgt = r_state[i];
      if (r_state[i] != S_IDLE) w_all_idle = 1'b0;
      if (r_state[i] inside {S_ACTIVATING, S_READING, S_WRITING}) w_pa_blocked = 1'b1;
    end

    // Same-direction restarts are the only commands accepted by a NOT_READY bank
    w_legal = 1'b0;
    if (w_b_ok) begin
      case (w_cmd)
        CMD_ACTIVE:    w_legal = (w_tgt == S_IDLE);
        CMD_READ:      w_legal = w_tgt inside {S_ACTIVE, S_READING, S_READ_SEMI, S_WRITE_SEMI};
        CMD_WRITE:     w_legal = w_tgt inside {S_ACTIVE, S_WRITING, S_WRITE_SEMI, S_READ_SEMI};
        CMD_PRECHARGE: w_legal = w_tgt inside {S_ACTIVE, S_READ_SEMI, S_WRITE_SEMI};
        default:       w_legal = 1'b0;
      endcase
    end

    w_bank_go  = w_bank_cmd && w_legal;
    w_pa_go    = w_pre_all && !w_pa_blocked;
    w_glob_go  = w_global && w_all_idle;
    w_err      = (w_bank_cmd && !w_legal) || (w_pre_all && w_pa_blocked) ||
                 (w_global && !w_all_idle);
    w_err_bank = w_bank_cmd ? bus.B : '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_nxt_state[i] = r_state[i];
      w_nxt_cnt[i]   = r_cnt[i];
      if (w_glob_go) begin
        w_nxt_state[i] = S_GLOBAL_BUSY;
        w_nxt_cnt[i]   = w_is_mrs ? C_MRD : C_RFC;
      end else if (w_pa_go && (r_state[i] inside {S_ACTIVE, S_READ_SEMI, S_WRITE_SEMI})) begin
        w_nxt_state[i] = S_PRECHARGING;
        w_nxt_cnt[i]   = C_RP;
      end else if (w_bank_go && (bus.B == BANK_W'(i))) begin
        case (w_cmd)
          CMD_ACTIVE: begin
            w_nxt_state[i] = S_ACTIVATING;
            w_nxt_cnt[i]   = C_RCD;
          end
          CMD_READ: begin
            w_nxt_state[i] = S_READING;
            w_nxt_cnt[i]   = burst_load(bus.pool_rburst_size);
          end
          CMD_WRITE: begin
            w_nxt_state[i] = S_WRITING;
            w_nxt_cnt[i]   = burst_load(bus.pool_wburst_size);
          end
          default: begin
            w_nxt_state[i] = S_PRECHARGING;
            w_nxt_cnt[i]   = C_RP;
          end
        endcase
      end else if (r_state[i] != S_IDLE && r_state[i] != S_ACTIVE) begin
        if (r_cnt[i] != '0) begin
          w_nxt_cnt[i] = r_cnt[i] - CNT_W'(1);
        end else begin
          case (r_state[i])
            S_READING: begin
              w_nxt_state[i] = S_READ_SEMI;
              w_nxt_cnt[i]   = C_RDT;
            end
            S_WRITING: begin
              w_nxt_state[i] = S_WRITE_SEMI;
              w_nxt_cnt[i]   = C_WRT;
            end
            S_ACTIVATING, S_READ_SEMI, S_WRITE_SEMI: w_nxt_state[i] = S_ACTIVE;
            default:                                 w_nxt_state[i] = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i]  <= S_IDLE;
        r_cnt[i]    <= '0;
        r_status[i] <= BANK_FULL_READY;
      end
      r_open     <= '0;
      r_err      <= 1'b0;
      r_err_bank <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i]  <= w_nxt_state[i];
        r_cnt[i]    <= w_nxt_cnt[i];
        r_status[i] <= status_of(w_nxt_state[i]);
        r_open[i]   <= is_open(w_nxt_state[i]);
      end
      r_err <= w_err;
      if (w_err) r_err_bank <= w_err_bank;
    end
  end

  assign bus.bank_status  = r_status;
  assign bus.bank_open    = r_open;
  assign bus.all_idle     = w_all_idle;
  assign bus.cmd_err      = r_err;
  assign bus.cmd_err_bank = r_err_bank;

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_monitor.sv
`default_nettype none
// ============================================================================
// tb_multi_bank_monitor
// Directed command vectors with a queued expected-response scoreboard.
// Revision: 1.0
// ============================================================================
module tb_multi_bank_monitor;
  import multi_bank_monitor_pkg::*;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  multi_bank_monitor_if #(.NUM_BANKS(4), .BANK_W(2)) bus ();

  multi_bank_monitor #(.NUM_BANKS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] st;
    logic [3:0] op;
    logic       idle;
    logic       err;
    logic [1:0] eb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   step_no = 0;

  // Status string is written bank3..bank0: F=full, N=not ready, R=read, W=write ready
  function automatic logic [7:0] st(input string s);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      case (s[3-i])
        "N":     v[2*i +: 2] = 2'd0;
        "R":     v[2*i +: 2] = 2'd1;
        "W":     v[2*i +: 2] = 2'd2;
        default: v[2*i +: 2] = 2'd3;
      endcase
    end
    return v;
  endfunction

  task automatic cmp(input string tag, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", tag, id, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    logic [7:0] a_st;
    a_st = bus.bank_status;
    cmp("bank_status",  e.id, 32'(a_st),             32'(e.st));
    cmp("bank_open",    e.id, 32'(bus.bank_open),    32'(e.op));
    cmp("all_idle",     e.id, 32'(bus.all_idle),     32'(e.idle));
    cmp("cmd_err",      e.id, 32'(bus.cmd_err),      32'(e.err));
    cmp("cmd_err_bank", e.id, 32'(bus.cmd_err_bank), 32'(e.eb));
  endtask

  function automatic exp_t mk(input int id, input string s, input logic [3:0] op,
                              input logic idle, input logic err, input logic [1:0] eb);
    exp_t e;
    e.id = id; e.st = st(s); e.op = op; e.idle = idle; e.err = err; e.eb = eb;
    return e;
  endfunction

  task automatic step(input logic [3:0] cmd, input logic [1:0] b, input logic a10,
                      input string s, input logic [3:0] op, input logic idle,
                      input logic err, input logic [1:0] eb);
    @(negedge clk);
    {bus.CS, bus.RAS, bus.CAS, bus.WE} = cmd;
    bus.B   = b;
    bus.A10 = a10;
    step_no++;
    exp_q.push_back(mk(step_no, s, op, idle, err, eb));
  endtask

  task automatic nop(input string s, input logic [3:0] op, input logic idle,
                     input logic err, input logic [1:0] eb);
    step(CMD_NOP, 2'd0, 1'b0, s, op, idle, err, eb);
  endtask

  // Result of the command driven at a negedge is checked just after the next posedge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_outputs(exp_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    {bus.CS, bus.RAS, bus.CAS, bus.WE} = CMD_NOP;
    bus.B = 2'd0;
    bus.A10 = 1'b0;
    bus.pool_rburst_size = ONE_BYTE;
    bus.pool_wburst_size = ONE_BYTE;
    repeat (2) @(negedge clk);
    check_outputs(mk(0, "FFFF", 4'b0000, 1'b1, 1'b0, 2'd0));
    n_rst = 1'b1;

    // Activate bank 2
    step(CMD_ACTIVE, 2'd2, 1'b0, "FNFF", 4'b0100, 1'b0, 1'b0, 2'd0);
    nop("FNFF", 4'b0100, 1'b0, 1'b0, 2'd0);
    nop("FFFF", 4'b0100, 1'b0, 1'b0, 2'd0);

    // Bank 1 eight-byte read, restarted while still reading
    step(CMD_ACTIVE, 2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFFF", 4'b0110, 1'b0, 1'b0, 2'd0);
    bus.pool_rburst_size = EIGHT_BYTES;
    step(CMD_READ, 2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    step(CMD_READ, 2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFRF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFRF", 4'b0110, 1'b0, 1'b0, 2'd0);
    nop("FFFF", 4'b0110, 1'b0, 1'b0, 2'd0);

    // WRITE during READING is rejected; WRITE from READ_SEMI_DONE is accepted
    bus.pool_rburst_size = FOUR_BYTES;
    step(CMD_READ,  2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b0, 2'd0);
    step(CMD_WRITE, 2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b1, 2'd1);
    nop("FFRF", 4'b0110, 1'b0, 1'b0, 2'd1);
    bus.pool_wburst_size = ONE_BYTE;
    step(CMD_WRITE, 2'd1, 1'b0, "FFNF", 4'b0110, 1'b0, 1'b0, 2'd1);
    nop("FFWF", 4'b0110, 1'b0, 1'b0, 2'd1);
    nop("FFFF", 4'b0110, 1'b0, 1'b0, 2'd1);

    // Open banks 0 and 3; precharge-all blocked while bank 3 is activating
    step(CMD_ACTIVE,    2'd0, 1'b0, "FFFN", 4'b0111, 1'b0, 1'b0, 2'd1);
    step(CMD_ACTIVE,    2'd3, 1'b0, "NFFN", 4'b1111, 1'b0, 1'b0, 2'd1);
    step(CMD_PRECHARGE, 2'd0, 1'b1, "NFFF", 4'b1111, 1'b0, 1'b1, 2'd0);
    nop("FFFF", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(CMD_ACTIVE,       2'd3, 1'b0, "FFFF", 4'b1111, 1'b0, 1'b1, 2'd3);
    step(CMD_AUTO_REFRESH, 2'd2, 1'b0, "FFFF", 4'b1111, 1'b0, 1'b1, 2'd0);
    step(CMD_PRECHARGE,    2'd0, 1'b1, "NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd0);

    // Refresh from all idle
    step(CMD_AUTO_REFRESH, 2'd0, 1'b0, "NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("NNNN", 4'b0000, 1'b0, 1'b0, 2'd0);
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd0);

    // READ to idle bank 2, then MRS
    step(CMD_READ, 2'd2, 1'b0, "FFFF", 4'b0000, 1'b1, 1'b1, 2'd2);
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd2);
    step(CMD_MRS, 2'd0, 1'b0, "NNNN", 4'b0000, 1'b0, 1'b0, 2'd2);
    nop("NNNN", 4'b0000, 1'b0, 1'b0, 2'd2);
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd2);

    // Single-bank precharge
    step(CMD_ACTIVE, 2'd1, 1'b0, "FFNF", 4'b0010, 1'b0, 1'b0, 2'd2);
    nop("FFNF", 4'b0010, 1'b0, 1'b0, 2'd2);
    nop("FFFF", 4'b0010, 1'b0, 1'b0, 2'd2);
    step(CMD_PRECHARGE, 2'd1, 1'b0, "FFNF", 4'b0000, 1'b0, 1'b0, 2'd2);
    nop("FFNF", 4'b0000, 1'b0, 1'b0, 2'd2);
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd2);

    // Asynchronous reset while bank 1 is writing and an error pulse is up
    step(CMD_ACTIVE, 2'd1, 1'b0, "FFNF", 4'b0010, 1'b0, 1'b0, 2'd2);
    nop("FFNF", 4'b0010, 1'b0, 1'b0, 2'd2);
    nop("FFFF", 4'b0010, 1'b0, 1'b0, 2'd2);
    bus.pool_wburst_size = EIGHT_BYTES;
    step(CMD_WRITE, 2'd1, 1'b0, "FFNF", 4'b0010, 1'b0, 1'b0, 2'd2);
    step(CMD_READ,  2'd1, 1'b0, "FFNF", 4'b0010, 1'b0, 1'b1, 2'd1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_outputs(mk(100, "FFFF", 4'b0000, 1'b1, 1'b0, 2'd0));
    {bus.CS, bus.RAS, bus.CAS, bus.WE} = CMD_NOP;
    @(negedge clk);
    n_rst = 1'b1;
    nop("FFFF", 4'b0000, 1'b1, 1'b0, 2'd0);
    step(CMD_ACTIVE, 2'd0, 1'b0, "FFFN", 4'b0001, 1'b0, 1'b0, 2'd0);
    nop("FFFN", 4'b0001, 1'b0, 1'b0, 2'd0);

    repeat (2) @(posedge clk);
    #2;
    cmp("queue_drained", 999, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
